// File: rtl/issue_unit.sv
// Per-SM warp issue arbiter: one-hot issue grant and independent exit grant; ISSUE_GTO_EN enables greedy-then-oldest bursts.
// Latency: grants are combinational in the request cycle; pointers and counters update on the next rising edge.
// Backpressure: Full_OC_IB=1 blocks issue grants, freezes issue state and counts stall cycles; exit grants ignore it.
module issue_unit #(
  parameter int NUM_WARPS    = 8,
  parameter int LOGNUM_WARPS = $clog2(NUM_WARPS)
`ifdef ISSUE_GTO_EN
  ,
  parameter int MAX_BURST    = 4
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_WARPS-1:0]    Req_IB_IU,
  input  logic [NUM_WARPS-1:0]    Exit_Req_IB_IU,
  input  logic                    Full_OC_IB,
  output logic [NUM_WARPS-1:0]    Grt_IU_IB,
  output logic [NUM_WARPS-1:0]    Exit_Grt_IU_IB,
  output logic [LOGNUM_WARPS-1:0] Last_WarpID_IU,
  output logic [31:0]             Stall_Cycles_IU
);

  logic [NUM_WARPS-1:0]    eff;
  logic [LOGNUM_WARPS-1:0] rr_ptr;
  logic [LOGNUM_WARPS-1:0] ex_ptr;
  logic [LOGNUM_WARPS-1:0] rr_idx;
  logic [LOGNUM_WARPS-1:0] ex_idx;
  logic                    rr_found;
  logic                    ex_found;
  logic                    iss_vld;
  logic                    rr_adv;
  logic [LOGNUM_WARPS-1:0] iss_idx;
  logic                    ex_vld;

  // A warp that is exiting is never offered to the issue side.
  assign eff = Req_IB_IU & ~Exit_Req_IB_IU;

  always_comb begin
    logic [LOGNUM_WARPS-1:0] cand;
    rr_found = 1'b0;
    rr_idx   = '0;
    ex_found = 1'b0;
    ex_idx   = '0;
    cand     = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      cand = rr_ptr + LOGNUM_WARPS'(i);
      if (!rr_found && eff[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
      cand = ex_ptr + LOGNUM_WARPS'(i);
      if (!ex_found && Exit_Req_IB_IU[cand]) begin
        ex_found = 1'b1;
        ex_idx   = cand;
      end
    end
  end

`ifdef ISSUE_GTO_EN
  logic                    greedy_vld;
  logic [LOGNUM_WARPS-1:0] greedy_id;
  logic [3:0]              burst_cnt;
  logic                    greedy_hit;

  assign greedy_hit = greedy_vld && eff[greedy_id] && (burst_cnt < 4'(MAX_BURST));
  assign iss_vld    = rst && !Full_OC_IB && rr_found;
  assign iss_idx    = greedy_hit ? greedy_id : rr_idx;
  assign rr_adv     = iss_vld && !greedy_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      greedy_vld <= 1'b0;
      greedy_id  <= '0;
      burst_cnt  <= '0;
    end else begin
      // An exiting greedy warp loses its slot; a new round-robin winner below overrides this.
      if (ex_vld && greedy_vld && (ex_idx == greedy_id))
        greedy_vld <= 1'b0;
      if (iss_vld) begin
        if (greedy_hit) begin
          burst_cnt <= burst_cnt + 4'd1;
        end else begin
          greedy_vld <= 1'b1;
          greedy_id  <= rr_idx;
          burst_cnt  <= 4'd1;
        end
      end
    end
  end
`else
  assign iss_vld = rst && !Full_OC_IB && rr_found;
  assign iss_idx = rr_idx;
  assign rr_adv  = iss_vld;
`endif

  assign ex_vld         = rst && ex_found;
  assign Grt_IU_IB      = iss_vld ? (NUM_WARPS'(1) << iss_idx) : '0;
  assign Exit_Grt_IU_IB = ex_vld  ? (NUM_WARPS'(1) << ex_idx)  : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr          <= '0;
      ex_ptr          <= '0;
      Last_WarpID_IU  <= '0;
      Stall_Cycles_IU <= '0;
    end else begin
      if (rr_adv)
        rr_ptr <= rr_idx + LOGNUM_WARPS'(1);
      if (ex_vld)
        ex_ptr <= ex_idx + LOGNUM_WARPS'(1);
      if (iss_vld)
        Last_WarpID_IU <= iss_idx;
      if ((|Req_IB_IU) && Full_OC_IB && (Stall_Cycles_IU != 32'hFFFF_FFFF))
        Stall_Cycles_IU <= Stall_Cycles_IU + 32'd1;
    end
  end

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: round robin, operand-collector backpressure, exit arbitration, reset.
module tb_issue_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  req = '0;
  logic [7:0]  ex_req = '0;
  logic        full = 1'b0;
  logic [7:0]  grt;
  logic [7:0]  ex_grt;
  logic [2:0]  last_id;
  logic [31:0] stall;
  int          checks = 0;
  int          errors = 0;

  issue_unit dut (
    .clk            (clk),
    .rst            (rst),
    .Req_IB_IU      (req),
    .Exit_Req_IB_IU (ex_req),
    .Full_OC_IB     (full),
    .Grt_IU_IB      (grt),
    .Exit_Grt_IU_IB (ex_grt),
    .Last_WarpID_IU (last_id),
    .Stall_Cycles_IU(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    req = '0;
    ex_req = '0;
    full = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_grt;
    // Requests present during reset must not be granted or counted.
    req = 8'hFF;
    ex_req = 8'h01;
    full = 1'b1;
    #3;
    chk("rst_grt", grt, 8'h00);
    chk("rst_exgrt", ex_grt, 8'h00);
    cyc;
    chk("rst_last", last_id, 3'd0);
    chk("rst_stall", stall, 32'd0);
    rst = 1'b1;
    full = 1'b0;
    ex_req = 8'h00;

`ifndef ISSUE_GTO_EN
    for (int k = 0; k < 9; k++) begin
      #1;
      chk($sformatf("rr_grt%0d", k), grt, 32'(8'h01 << (k % 8)));
      chk($sformatf("rr_last%0d", k), last_id, (k == 0) ? 32'd0 : 32'((k - 1) % 8));
      cyc;
    end
    chk("rr_last_wrap", last_id, 3'd0);

    req = 8'h24;
    full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("full_grt%0d", k), grt, 8'h00);
      cyc;
    end
    chk("full_stall", stall, 32'd3);
    chk("full_last_hold", last_id, 3'd0);
    full = 1'b0;
    #1;
    chk("release_w2", grt, 8'h04);
    cyc;
    req = 8'h20;
    #1;
    chk("release_w5", grt, 8'h20);
    cyc;
    req = 8'h00;
    chk("release_last", last_id, 3'd5);
    chk("release_stall", stall, 32'd3);
`endif

    cyc;
    do_reset;
    req = 8'h08;
    ex_req = 8'h09;
    #1;
    chk("exit_first", ex_grt, 8'h01);
    chk("exit_mask_issue", grt, 8'h00);
    cyc;
    chk("exit_second", ex_grt, 8'h08);
    chk("exit_mask_issue2", grt, 8'h00);
    cyc;
    full = 1'b1;
    req = 8'h02;
    ex_req = 8'h80;
    #1;
    chk("exit_full", ex_grt, 8'h80);
    chk("exit_full_issue", grt, 8'h00);
    cyc;
    chk("exit_full_stall", stall, 32'd1);
    full = 1'b0;
    ex_req = 8'h01;
    #1;
    chk("both_exit", ex_grt, 8'h01);
    chk("both_issue", grt, 8'h02);
    cyc;
    chk("both_last", last_id, 3'd1);
    ex_req = 8'h00;
    req = 8'h00;

    cyc;
    do_reset;
    req = 8'hC0;
    #1;
    chk("mid_first", grt, 8'h40);
    cyc;
`ifdef ISSUE_GTO_EN
    exp_grt = 8'h40;
`else
    exp_grt = 8'h80;
`endif
    chk("mid_second", grt, exp_grt);
    chk("mid_last", last_id, 3'd6);
    ex_req = 8'h01;
    rst = 1'b0;
    #1;
    chk("mid_rst_grt", grt, 8'h00);
    chk("mid_rst_exgrt", ex_grt, 8'h00);
    chk("mid_rst_last", last_id, 3'd0);
    chk("mid_rst_stall", stall, 32'd0);
    rst = 1'b1;
    ex_req = 8'h00;
    #1;
    chk("mid_restart", grt, 8'h40);
    cyc;
    chk("mid_restart_last", last_id, 3'd6);
    req = 8'h00;

`ifdef ISSUE_GTO_EN
    begin
      int seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      cyc;
      do_reset;
      req = 8'h03;
      for (int k = 0; k < 9; k++) begin
        #1;
        chk($sformatf("gto_grt%0d", k), grt, 32'(8'h01 << seq[k]));
        cyc;
      end
      req = 8'h00;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
